// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 framing with a one-entry holding register and
// per-frame baud selection. Bit periods assume a 25 MHz system clock.

`ifndef BAUD_RATE_115200
`define BAUD_RATE_115200 13'd217
`endif
`ifndef BAUD_RATE_57600
`define BAUD_RATE_57600 13'd434
`endif
`ifndef BAUD_RATE_38400
`define BAUD_RATE_38400 13'd651
`endif
`ifndef BAUD_RATE_9600
`define BAUD_RATE_9600 13'd2604
`endif

module uart_tx #(
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] baud_sel,
   input  logic [7:0] tx_din,
   input  logic       tx_vld,
   output logic       tx_rdy,
   output logic       tx_dout,
   output logic       tx_busy,
   output logic       tx_done
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   state_t      state_q;
   logic [7:0]  hold_q;
   logic        hold_full_q;
   logic [7:0]  shift_q;
   logic [12:0] baud_cnt_q;
   logic [12:0] period_q;
   logic [12:0] period_d;
   logic [3:0]  bit_cnt_q;
   logic        tx_dout_q;
   logic        tx_busy_q;
   logic        tx_done_q;

   logic        hs;
   logic        bit_end;
   logic        last_stop;
   logic        reload;

   always_comb begin
      period_d = `BAUD_RATE_115200;
      case (baud_sel)
         2'd1:    period_d = `BAUD_RATE_57600;
         2'd2:    period_d = `BAUD_RATE_38400;
         2'd3:    period_d = `BAUD_RATE_9600;
         default: period_d = `BAUD_RATE_115200;
      endcase
   end

   assign hs        = tx_vld && !hold_full_q;
   assign bit_end   = (baud_cnt_q == (period_q - 13'd1));
   assign last_stop = (bit_cnt_q == LAST_STOP);
   // Hold-to-shift transfer: from IDLE, or straight out of the last stop bit.
   assign reload    = hold_full_q &&
                      ((state_q == IDLE) || ((state_q == STOP) && bit_end && last_stop));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         baud_cnt_q  <= '0;
         period_q    <= `BAUD_RATE_115200;
         bit_cnt_q   <= '0;
         tx_dout_q   <= 1'b1;
         tx_busy_q   <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         tx_done_q <= 1'b0;
         tx_busy_q <= (state_q != IDLE);
         case (state_q)
            START:   tx_dout_q <= 1'b0;
            DATA:    tx_dout_q <= shift_q[0];
            default: tx_dout_q <= 1'b1;
         endcase

         // A new byte takes priority so it is never lost when hold drains.
         if (hs) begin
            hold_q      <= tx_din;
            hold_full_q <= 1'b1;
         end else if (reload) begin
            hold_full_q <= 1'b0;
         end

         if (reload) begin
            shift_q  <= hold_q;
            period_q <= period_d;
         end

         case (state_q)
            IDLE: begin
               baud_cnt_q <= '0;
               bit_cnt_q  <= '0;
               if (hold_full_q) state_q <= START;
            end
            START: begin
               if (bit_end) begin
                  baud_cnt_q <= '0;
                  bit_cnt_q  <= '0;
                  state_q    <= DATA;
               end else begin
                  baud_cnt_q <= baud_cnt_q + 13'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt_q <= '0;
                  shift_q    <= {1'b0, shift_q[7:1]};
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_q <= '0;
                     state_q   <= STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + 13'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt_q <= '0;
                  if (last_stop) begin
                     bit_cnt_q <= '0;
                     tx_done_q <= 1'b1;
                     state_q   <= hold_full_q ? START : IDLE;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + 13'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_rdy  = !hold_full_q;
   assign tx_dout = tx_dout_q;
   assign tx_busy = tx_busy_q;
   assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: framing, latency, back-to-back, baud latch,
// mid-frame reset and two-stop-bit framing (second instance).

module tb_uart_tx;

   localparam int B0 = 217;   // 115200 at 25 MHz
   localparam int B3 = 2604;  // 9600 at 25 MHz

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] baud_sel = 2'd0;
   logic [7:0] tx_din = 8'h00;
   logic       tx_vld = 1'b0;
   logic       tx_rdy, tx_dout, tx_busy, tx_done;

   logic [1:0] baud_sel2 = 2'd0;
   logic [7:0] tx_din2 = 8'h00;
   logic       tx_vld2 = 1'b0;
   logic       tx_rdy2, tx_dout2, tx_busy2, tx_done2;

   int tests = 0;
   int failed = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done2_cnt = 0;
   int done_cyc[64];

   uart_tx #(.STOP_BITS(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .baud_sel(baud_sel), .tx_din(tx_din), .tx_vld(tx_vld),
      .tx_rdy(tx_rdy), .tx_dout(tx_dout), .tx_busy(tx_busy), .tx_done(tx_done));

   uart_tx #(.STOP_BITS(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .baud_sel(baud_sel2), .tx_din(tx_din2), .tx_vld(tx_vld2),
      .tx_rdy(tx_rdy2), .tx_dout(tx_dout2), .tx_busy(tx_busy2), .tx_done(tx_done2));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_done === 1'b1) begin
         if (done_cnt < 64) done_cyc[done_cnt] = cyc;
         done_cnt++;
      end
      if (tx_done2 === 1'b1) done2_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, required the bench to finish first");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (tx_dout !== 1'b1) begin failed++; $display("FAIL reset_dout: got %b want 1", tx_dout); end
      tests++; if (tx_rdy !== 1'b1) begin failed++; $display("FAIL reset_rdy: got %b want 1", tx_rdy); end
      tests++; if (tx_busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
      tests++; if (tx_done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b want 0", tx_done); end
      tests++; if (tx_dout2 !== 1'b1) begin failed++; $display("FAIL reset_dout2: got %b want 1", tx_dout2); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_a5();
      logic [9:0] fr;
      int d0;
      fr = {1'b1, 8'hA5, 1'b0};
      @(negedge clk);
      d0 = done_cnt;
      baud_sel = 2'd0;
      tx_din = 8'hA5; tx_vld = 1'b1;
      @(negedge clk);
      tx_vld = 1'b0;
      @(negedge clk);
      tests++; if (tx_dout !== 1'b1) begin failed++; $display("FAIL a5_latency_idle: got %b want 1", tx_dout); end
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         tests++; if (tx_dout !== fr[i]) begin failed++; $display("FAIL a5_bit%0d_first: got %b want %b", i, tx_dout, fr[i]); end
         if (i == 0) begin
            tests++; if (tx_busy !== 1'b1) begin failed++; $display("FAIL a5_busy: got %b want 1", tx_busy); end
         end
         repeat (B0 - 1) @(negedge clk);
         tests++; if (tx_dout !== fr[i]) begin failed++; $display("FAIL a5_bit%0d_last: got %b want %b", i, tx_dout, fr[i]); end
         tests++; if (tx_done !== (i == 9)) begin failed++; $display("FAIL a5_done_bit%0d: got %b want %b", i, tx_done, (i == 9)); end
         @(negedge clk);
      end
      tests++; if (tx_dout !== 1'b1) begin failed++; $display("FAIL a5_idle_dout: got %b want 1", tx_dout); end
      tests++; if (tx_busy !== 1'b0) begin failed++; $display("FAIL a5_idle_busy: got %b want 0", tx_busy); end
      tests++; if (done_cnt - d0 != 1) begin failed++; $display("FAIL a5_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_back_to_back();
      logic [19:0] fr;
      int d0;
      fr = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
      @(negedge clk);
      d0 = done_cnt;
      tx_din = 8'h00; tx_vld = 1'b1;
      @(negedge clk);
      tx_din = 8'hFF;
      tests++; if (tx_rdy !== 1'b0) begin failed++; $display("FAIL b2b_rdy_full: got %b want 0", tx_rdy); end
      @(negedge clk);
      tests++; if (tx_rdy !== 1'b1) begin failed++; $display("FAIL b2b_rdy_drained: got %b want 1", tx_rdy); end
      @(negedge clk);
      tx_vld = 1'b0;
      tests++; if (tx_rdy !== 1'b0) begin failed++; $display("FAIL b2b_rdy_second: got %b want 0", tx_rdy); end
      for (int i = 0; i < 20; i++) begin
         tests++; if (tx_dout !== fr[i]) begin failed++; $display("FAIL b2b_bit%0d_first: got %b want %b", i, tx_dout, fr[i]); end
         if (i == 9) begin
            tests++; if (tx_rdy !== 1'b0) begin failed++; $display("FAIL b2b_rdy_held: got %b want 0", tx_rdy); end
         end
         repeat (B0 - 1) @(negedge clk);
         tests++; if (tx_dout !== fr[i]) begin failed++; $display("FAIL b2b_bit%0d_last: got %b want %b", i, tx_dout, fr[i]); end
         tests++; if (tx_done !== (i == 9 || i == 19)) begin failed++; $display("FAIL b2b_done_bit%0d: got %b want %b", i, tx_done, (i == 9 || i == 19)); end
         if (i == 9) begin
            tests++; if (tx_rdy !== 1'b1) begin failed++; $display("FAIL b2b_rdy_transfer: got %b want 1", tx_rdy); end
         end
         @(negedge clk);
      end
      tests++; if (tx_busy !== 1'b0) begin failed++; $display("FAIL b2b_idle_busy: got %b want 0", tx_busy); end
      tests++; if (done_cnt - d0 != 2) begin failed++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
   endtask

   task automatic test_three();
      logic [7:0] got[3];
      logic [9:0] fr;
      int hs[3];
      int d0, n1, n2;
      @(negedge clk);
      d0 = done_cnt;
      baud_sel = 2'd0;
      fork
         begin
            for (int b = 0; b < 3; b++) begin
               tx_din = 8'(b + 1); tx_vld = 1'b1;
               n1 = 0;
               while (!tx_rdy && n1 < 40 * B0) begin @(negedge clk); n1++; end
               tests++; if (n1 >= 40 * B0) begin failed++; $display("FAIL three_hs_timeout%0d: waited %0d cycles, want fewer than %0d", b, n1, 40 * B0); end
               hs[b] = cyc + 1;
               @(negedge clk);
            end
            tx_vld = 1'b0;
         end
         begin
            for (int f = 0; f < 3; f++) begin
               n2 = 0;
               while (tx_dout !== 1'b0 && n2 < 30 * B0) begin @(negedge clk); n2++; end
               tests++; if (n2 >= 30 * B0) begin failed++; $display("FAIL three_start_timeout%0d: waited %0d cycles, want fewer than %0d", f, n2, 30 * B0); end
               repeat (B0 / 2) @(negedge clk);
               for (int j = 0; j < 10; j++) begin
                  fr[j] = tx_dout;
                  if (j < 9) repeat (B0) @(negedge clk);
               end
               got[f] = fr[8:1];
               tests++; if (fr[0] !== 1'b0 || fr[9] !== 1'b1) begin failed++; $display("FAIL three_framing%0d: start=%b stop=%b want 0/1", f, fr[0], fr[9]); end
            end
         end
      join
      for (int f = 0; f < 3; f++) begin
         tests++; if (got[f] !== 8'(f + 1)) begin failed++; $display("FAIL three_order%0d: got %h want %h", f, got[f], 8'(f + 1)); end
      end
      tests++; if (hs[1] != hs[0] + 2) begin failed++; $display("FAIL three_hs1_cycle: got %0d want %0d", hs[1], hs[0] + 2); end
      tests++; if (hs[2] != done_cyc[d0] + 1) begin failed++; $display("FAIL three_hs2_stall: got %0d want %0d", hs[2], done_cyc[d0] + 1); end
      repeat (B0) @(negedge clk);
      tests++; if (done_cnt - d0 != 3) begin failed++; $display("FAIL three_done_count: got %0d want 3", done_cnt - d0); end
      tests++; if (tx_busy !== 1'b0) begin failed++; $display("FAIL three_idle_busy: got %b want 0", tx_busy); end
   endtask

   task automatic test_baud_change();
      logic [9:0] fr;
      logic [9:0] fr2;
      fr  = {1'b1, 8'h55, 1'b0};
      fr2 = {1'b1, 8'hC3, 1'b0};
      @(negedge clk);
      baud_sel = 2'd3;
      tx_din = 8'h55; tx_vld = 1'b1;
      @(negedge clk);
      tx_vld = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         tests++; if (tx_dout !== fr[i]) begin failed++; $display("FAIL baud9600_bit%0d_first: got %b want %b", i, tx_dout, fr[i]); end
         if (i == 2) baud_sel = 2'd0;
         repeat (B3 - 1) @(negedge clk);
         tests++; if (tx_dout !== fr[i]) begin failed++; $display("FAIL baud9600_bit%0d_last: got %b want %b", i, tx_dout, fr[i]); end
         tests++; if (tx_done !== (i == 9)) begin failed++; $display("FAIL baud9600_done_bit%0d: got %b want %b", i, tx_done, (i == 9)); end
         @(negedge clk);
      end
      tx_din = 8'hC3; tx_vld = 1'b1;
      @(negedge clk);
      tx_vld = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         tests++; if (tx_dout !== fr2[i]) begin failed++; $display("FAIL baudnext_bit%0d_first: got %b want %b", i, tx_dout, fr2[i]); end
         repeat (B0 - 1) @(negedge clk);
         tests++; if (tx_dout !== fr2[i]) begin failed++; $display("FAIL baudnext_bit%0d_last: got %b want %b", i, tx_dout, fr2[i]); end
         @(negedge clk);
      end
      tests++; if (tx_busy !== 1'b0) begin failed++; $display("FAIL baudnext_idle_busy: got %b want 0", tx_busy); end
   endtask

   task automatic test_reset_mid();
      logic [9:0] fr;
      int d0, lows;
      fr = {1'b1, 8'h96, 1'b0};
      @(negedge clk);
      baud_sel = 2'd0;
      tx_din = 8'h00; tx_vld = 1'b1;
      @(negedge clk);
      tx_vld = 1'b0;
      repeat (2) @(negedge clk);
      d0 = done_cnt;
      repeat (B0) @(negedge clk);
      tx_din = 8'h77; tx_vld = 1'b1;
      @(negedge clk);
      tx_vld = 1'b0;
      tests++; if (tx_rdy !== 1'b0) begin failed++; $display("FAIL rstmid_hold_full: got %b want 0", tx_rdy); end
      repeat (3 * B0 + B0 / 2 - 1) @(negedge clk);
      tests++; if (tx_dout !== 1'b0) begin failed++; $display("FAIL rstmid_bit3: got %b want 0", tx_dout); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (tx_dout !== 1'b1) begin failed++; $display("FAIL rstmid_dout: got %b want 1", tx_dout); end
      tests++; if (tx_busy !== 1'b0) begin failed++; $display("FAIL rstmid_busy: got %b want 0", tx_busy); end
      tests++; if (tx_rdy !== 1'b1) begin failed++; $display("FAIL rstmid_rdy: got %b want 1", tx_rdy); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      lows = 0;
      for (int c = 0; c < 3 * B0; c++) begin
         @(negedge clk);
         if (tx_dout !== 1'b1 || tx_busy !== 1'b0) lows++;
      end
      tests++; if (lows != 0) begin failed++; $display("FAIL rstmid_discard: %0d active cycles, want 0", lows); end
      tests++; if (done_cnt != d0) begin failed++; $display("FAIL rstmid_no_done: got %0d want %0d", done_cnt, d0); end
      tx_din = 8'h96; tx_vld = 1'b1;
      @(negedge clk);
      tx_vld = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         tests++; if (tx_dout !== fr[i]) begin failed++; $display("FAIL rstmid_fresh_bit%0d_first: got %b want %b", i, tx_dout, fr[i]); end
         repeat (B0 - 1) @(negedge clk);
         tests++; if (tx_dout !== fr[i]) begin failed++; $display("FAIL rstmid_fresh_bit%0d_last: got %b want %b", i, tx_dout, fr[i]); end
         @(negedge clk);
      end
      tests++; if (done_cnt - d0 != 1) begin failed++; $display("FAIL rstmid_fresh_done: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_stop2();
      logic [10:0] fr;
      int d0;
      fr = {2'b11, 8'h3C, 1'b0};
      @(negedge clk);
      d0 = done2_cnt;
      baud_sel2 = 2'd0;
      tx_din2 = 8'h3C; tx_vld2 = 1'b1;
      @(negedge clk);
      tx_vld2 = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         tests++; if (tx_dout2 !== fr[i]) begin failed++; $display("FAIL stop2_bit%0d_first: got %b want %b", i, tx_dout2, fr[i]); end
         repeat (B0 - 1) @(negedge clk);
         tests++; if (tx_dout2 !== fr[i]) begin failed++; $display("FAIL stop2_bit%0d_last: got %b want %b", i, tx_dout2, fr[i]); end
         tests++; if (tx_done2 !== (i == 10)) begin failed++; $display("FAIL stop2_done_bit%0d: got %b want %b", i, tx_done2, (i == 10)); end
         @(negedge clk);
      end
      tests++; if (tx_busy2 !== 1'b0) begin failed++; $display("FAIL stop2_idle_busy: got %b want 0", tx_busy2); end
      tests++; if (done2_cnt - d0 != 1) begin failed++; $display("FAIL stop2_done_count: got %0d want 1", done2_cnt - d0); end
   endtask

   initial begin
      test_reset();
      test_a5();
      test_back_to_back();
      test_three();
      test_baud_change();
      test_reset_mid();
      test_stop2();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
